// File: rtl/pwr_switch_ack_model_if.sv
// Handshake bundle between a power manager (master) and the switch-cell model (slave).
interface pwr_switch_ack_model_if #(
   parameter int NUM_DOMAINS = 4
);
   logic [NUM_DOMAINS-1:0] switch_n_i;
   logic [NUM_DOMAINS-1:0] ack_n_o;
   logic [NUM_DOMAINS-1:0] busy_o;
   logic [NUM_DOMAINS-1:0] done_o;
   logic [NUM_DOMAINS-1:0] abort_o;
   logic                   all_stable_o;

   modport master (
      output switch_n_i,
      input  ack_n_o,
      input  busy_o,
      input  done_o,
      input  abort_o,
      input  all_stable_o
   );

   modport slave (
      input  switch_n_i,
      output ack_n_o,
      output busy_o,
      output done_o,
      output abort_o,
      output all_stable_o
   );
endinterface

// File: rtl/pwr_switch_ack_model.sv
// Cycle-accurate power-switch acknowledge model, one IDLE/RAMP channel per domain.
// Optional random extra ramp latency from an LFSR when PWR_SWITCH_ACK_JITTER_EN is defined.
//
// state | meaning
// IDLE  | ack_n matches the last completed request; waiting for a new one
// RAMP  | counting down toward ack_n <= target; withdrawal aborts
module pwr_switch_ack_model #(
   parameter int          NUM_DOMAINS = 4,
   parameter int          ON_LATENCY  = 15,
   parameter int          OFF_LATENCY = 15,
   parameter logic        RESET_ACK_N = 1'b0,
   parameter int          JITTER_W    = 2,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input logic                   clk_i,
   input logic                   rst_i,
   pwr_switch_ack_model_if.slave bus
);

   localparam int MAX_LAT = (ON_LATENCY > OFF_LATENCY) ? ON_LATENCY : OFF_LATENCY;
   localparam int CNT_W   = $clog2(MAX_LAT + (1 << JITTER_W));

   localparam logic [CNT_W-1:0] ON_CNT  = CNT_W'(ON_LATENCY);
   localparam logic [CNT_W-1:0] OFF_CNT = CNT_W'(OFF_LATENCY);
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RAMP = 1'b1;

   logic [0:0]             state_q [NUM_DOMAINS];
   logic [0:0]             state_d [NUM_DOMAINS];
   logic [CNT_W-1:0]       cnt_q   [NUM_DOMAINS];
   logic [CNT_W-1:0]       cnt_d   [NUM_DOMAINS];
   logic [CNT_W-1:0]       extra_w [NUM_DOMAINS];
   logic [CNT_W-1:0]       lat_w   [NUM_DOMAINS];
   logic [NUM_DOMAINS-1:0] tgt_q,   tgt_d;
   logic [NUM_DOMAINS-1:0] ack_n_q, ack_n_d;
   logic [NUM_DOMAINS-1:0] busy_q,  busy_d;
   logic [NUM_DOMAINS-1:0] done_q,  done_d;
   logic [NUM_DOMAINS-1:0] abort_q, abort_d;
   logic                   all_stable_q, all_stable_d;

`ifdef PWR_SWITCH_ACK_JITTER_EN
   logic [15:0]         lfsr_q, lfsr_d;
   logic [JITTER_W-1:0] jit_w [NUM_DOMAINS];

   // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
   assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= lfsr_d;
   end

   always_comb begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
         jit_w[i]   = '0;
         for (int j = 0; j < JITTER_W; j++) begin
            jit_w[i][j] = lfsr_q[(i + j) % 16];
         end
         extra_w[i] = CNT_W'(jit_w[i]);
      end
   end
`else
   always_comb begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
         extra_w[i] = '0;
      end
   end
`endif

   // Ramp length is chosen from the freshly sampled request, which becomes the target.
   always_comb begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
         lat_w[i] = (bus.switch_n_i[i] ? OFF_CNT : ON_CNT) + extra_w[i];
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         tgt_d[i]   = tgt_q[i];
         ack_n_d[i] = ack_n_q[i];
         busy_d[i]  = busy_q[i];
         done_d[i]  = 1'b0;
         abort_d[i] = 1'b0;
         case (state_q[i])
            S_IDLE: begin
               if (bus.switch_n_i[i] != ack_n_q[i]) begin
                  tgt_d[i] = bus.switch_n_i[i];
                  if (lat_w[i] == ONE_CNT) begin
                     ack_n_d[i] = bus.switch_n_i[i];
                     done_d[i]  = 1'b1;
                  end else begin
                     state_d[i] = S_RAMP;
                     cnt_d[i]   = lat_w[i] - ONE_CNT;
                     busy_d[i]  = 1'b1;
                  end
               end
            end
            S_RAMP: begin
               // Withdrawal is checked first so it beats a simultaneous expiry.
               if (bus.switch_n_i[i] != tgt_q[i]) begin
                  state_d[i] = S_IDLE;
                  cnt_d[i]   = '0;
                  busy_d[i]  = 1'b0;
                  abort_d[i] = 1'b1;
               end else if (cnt_q[i] == ONE_CNT) begin
                  state_d[i] = S_IDLE;
                  cnt_d[i]   = '0;
                  ack_n_d[i] = tgt_q[i];
                  busy_d[i]  = 1'b0;
                  done_d[i]  = 1'b1;
               end else begin
                  cnt_d[i]   = cnt_q[i] - ONE_CNT;
               end
            end
            default: begin
               state_d[i] = S_IDLE;
               cnt_d[i]   = '0;
               busy_d[i]  = 1'b0;
            end
         endcase
      end
   end

   assign all_stable_d = ~|busy_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_DOMAINS; i++) begin
            state_q[i] <= S_IDLE;
            cnt_q[i]   <= '0;
         end
         tgt_q        <= {NUM_DOMAINS{RESET_ACK_N}};
         ack_n_q      <= {NUM_DOMAINS{RESET_ACK_N}};
         busy_q       <= '0;
         done_q       <= '0;
         abort_q      <= '0;
         all_stable_q <= 1'b1;
      end else begin
         for (int i = 0; i < NUM_DOMAINS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         tgt_q        <= tgt_d;
         ack_n_q      <= ack_n_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         abort_q      <= abort_d;
         all_stable_q <= all_stable_d;
      end
   end

   assign bus.ack_n_o      = ack_n_q;
   assign bus.busy_o       = busy_q;
   assign bus.done_o       = done_q;
   assign bus.abort_o      = abort_q;
   assign bus.all_stable_o = all_stable_q;

endmodule

// File: tb/tb_pwr_switch_ack_model.sv
// Bench for pwr_switch_ack_model: dut0 (ON=4, OFF=7) and dut1 (ON=OFF=1) against a deadline-based model.
module tb_pwr_switch_ack_model;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pwr_switch_ack_model_if #(.NUM_DOMAINS(4)) bus0 ();
   pwr_switch_ack_model_if #(.NUM_DOMAINS(4)) bus1 ();

   pwr_switch_ack_model #(
      .NUM_DOMAINS(4), .ON_LATENCY(4), .OFF_LATENCY(7), .RESET_ACK_N(1'b0)
   ) dut0 (
      .clk_i(clk), .rst_i(rst), .bus(bus0)
   );

   pwr_switch_ack_model #(
      .NUM_DOMAINS(4), .ON_LATENCY(1), .OFF_LATENCY(1), .RESET_ACK_N(1'b0)
   ) dut1 (
      .clk_i(clk), .rst_i(rst), .bus(bus1)
   );

   int errors = 0;
   int checks = 0;
   int n_edge = 0;
   logic [3:0] sw0 = 4'b0000;
   logic [3:0] sw1 = 4'b0000;

   // Model: each channel either idle or ramping toward tgt with an absolute deadline edge.
   bit m_ack   [2][4];
   bit m_busy  [2][4];
   bit m_tgt   [2][4];
   bit m_done  [2][4];
   bit m_abort [2][4];
   int m_end   [2][4];

   function automatic void model_reset();
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 4; c++) begin
            m_ack[d][c] = 1'b0; m_busy[d][c] = 1'b0; m_tgt[d][c] = 1'b0;
            m_done[d][c] = 1'b0; m_abort[d][c] = 1'b0; m_end[d][c] = 0;
         end
   endfunction

   function automatic void model_step(input int d, input logic [3:0] sw, input int n);
      int lat;
      for (int c = 0; c < 4; c++) begin
         m_done[d][c]  = 1'b0;
         m_abort[d][c] = 1'b0;
         if (m_busy[d][c]) begin
            if (sw[c] != m_tgt[d][c]) begin
               m_abort[d][c] = 1'b1;
               m_busy[d][c]  = 1'b0;
            end else if (n == m_end[d][c]) begin
               m_ack[d][c]  = m_tgt[d][c];
               m_done[d][c] = 1'b1;
               m_busy[d][c] = 1'b0;
            end
         end else if (sw[c] != m_ack[d][c]) begin
            if (d == 0) lat = sw[c] ? 7 : 4;
            else        lat = 1;
            if (lat == 1) begin
               m_ack[d][c]  = sw[c];
               m_done[d][c] = 1'b1;
            end else begin
               m_busy[d][c] = 1'b1;
               m_tgt[d][c]  = sw[c];
               m_end[d][c]  = n + lat - 1;
            end
         end
      end
   endfunction

   // {ack, busy, done, abort, all_stable}
   function automatic logic [16:0] exp_vec(input int d);
      logic [3:0] a, b, dn, ab;
      for (int c = 0; c < 4; c++) begin
         a[c] = m_ack[d][c]; b[c] = m_busy[d][c];
         dn[c] = m_done[d][c]; ab[c] = m_abort[d][c];
      end
      return {a, b, dn, ab, ~|b};
   endfunction

   function automatic logic [16:0] obs0();
      return {bus0.ack_n_o, bus0.busy_o, bus0.done_o, bus0.abort_o, bus0.all_stable_o};
   endfunction

   function automatic logic [16:0] obs1();
      return {bus1.ack_n_o, bus1.busy_o, bus1.done_o, bus1.abort_o, bus1.all_stable_o};
   endfunction

   task automatic tick();
      bus0.switch_n_i = sw0;
      bus1.switch_n_i = sw1;
      n_edge++;
      model_step(0, sw0, n_edge);
      model_step(1, sw1, n_edge);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sw0 = 4'b0000; sw1 = 4'b0000;
      bus0.switch_n_i = sw0; bus1.switch_n_i = sw1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (obs0() !== 17'b0000_0000_0000_0000_1) begin
         errors++; $display("FAIL reset_dut0 got %b expected %b", obs0(), 17'b0000_0000_0000_0000_1);
      end
      checks++;
      if (obs1() !== 17'b0000_0000_0000_0000_1) begin
         errors++; $display("FAIL reset_dut1 got %b expected %b", obs1(), 17'b0000_0000_0000_0000_1);
      end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (obs0() !== exp_vec(0)) begin
            errors++; $display("FAIL post_reset cyc%0d got %b expected %b", k, obs0(), exp_vec(0));
         end
      end
   endtask

   task automatic test_power_off();
      int k_done = -1;
      bit busy_first;
      sw0[0] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 1) busy_first = bus0.busy_o[0];
         if (bus0.done_o[0] === 1'b1 && k_done < 0) k_done = k;
         checks++;
         if (obs0() !== exp_vec(0)) begin
            errors++; $display("FAIL power_off cyc%0d got %b expected %b", k, obs0(), exp_vec(0));
         end
      end
      checks++;
      if (busy_first !== 1'b1) begin
         errors++; $display("FAIL power_off_busy_start got %b expected 1", busy_first);
      end
      // Request sampled on tick 1, ack expected OFF-1 = 6 edges later.
      checks++;
      if (k_done !== 7) begin
         errors++; $display("FAIL power_off_latency got tick %0d expected 7", k_done);
      end
   endtask

   task automatic test_power_on();
      int k_done = -1;
      sw0[1] = 1'b1;
      repeat (9) tick();
      sw0[1] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (bus0.done_o[1] === 1'b1 && k_done < 0) k_done = k;
         checks++;
         if (obs0() !== exp_vec(0)) begin
            errors++; $display("FAIL power_on cyc%0d got %b expected %b", k, obs0(), exp_vec(0));
         end
      end
      checks++;
      if (k_done !== 4) begin
         errors++; $display("FAIL power_on_latency got tick %0d expected 4", k_done);
      end
      checks++;
      if (bus0.ack_n_o !== 4'b0001) begin
         errors++; $display("FAIL power_on_others got %b expected 0001", bus0.ack_n_o);
      end
   endtask

   task automatic test_abort();
      int k_done = -1;
      sw0[2] = 1'b1;
      repeat (3) tick();
      sw0[2] = 1'b0;
      tick();
      checks++;
      if (bus0.abort_o[2] !== 1'b1 || bus0.ack_n_o[2] !== 1'b0 || bus0.done_o[2] !== 1'b0
          || bus0.busy_o[2] !== 1'b0) begin
         errors++; $display("FAIL abort_pulse got abort=%b ack=%b done=%b busy=%b expected 1 0 0 0",
                            bus0.abort_o[2], bus0.ack_n_o[2], bus0.done_o[2], bus0.busy_o[2]);
      end
      repeat (6) begin
         tick();
         checks++;
         if (obs0() !== exp_vec(0)) begin
            errors++; $display("FAIL abort_idle got %b expected %b", obs0(), exp_vec(0));
         end
      end
      sw0[2] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (bus0.done_o[2] === 1'b1 && k_done < 0) k_done = k;
         checks++;
         if (obs0() !== exp_vec(0)) begin
            errors++; $display("FAIL abort_rereq cyc%0d got %b expected %b", k, obs0(), exp_vec(0));
         end
      end
      checks++;
      if (k_done !== 7) begin
         errors++; $display("FAIL abort_rereq_latency got tick %0d expected 7", k_done);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         for (int c = 0; c < 4; c++) begin
            if ($urandom_range(0, 5) == 0) sw0[c] = ~sw0[c];
            if ($urandom_range(0, 1) == 0) sw1[c] = ~sw1[c];
         end
         tick();
         checks++;
         if (obs0() !== exp_vec(0)) begin
            errors++; $display("FAIL random_dut0 cyc%0d got %b expected %b", k, obs0(), exp_vec(0));
         end
         checks++;
         if (obs1() !== exp_vec(1)) begin
            errors++; $display("FAIL random_dut1 cyc%0d got %b expected %b", k, obs1(), exp_vec(1));
         end
      end
   endtask

   task automatic test_lat1();
      logic [3:0] prev;
      for (int k = 0; k < 40; k++) begin
         sw1 = 4'($urandom);
         prev = sw1;
         tick();
         checks++;
         if (bus1.ack_n_o !== prev || bus1.busy_o !== 4'b0000 || bus1.all_stable_o !== 1'b1) begin
            errors++; $display("FAIL lat1 cyc%0d got ack=%b busy=%b stable=%b expected ack=%b busy=0000 stable=1",
                               k, bus1.ack_n_o, bus1.busy_o, bus1.all_stable_o, prev);
         end
      end
   endtask

   task automatic test_concurrent_reset();
      for (int c = 0; c < 4; c++) sw0[c] = ~m_ack[0][c];
      // Let any ramps from earlier tests drain before the simultaneous request.
      begin
         logic [3:0] req;
         req = sw0;
         for (int c = 0; c < 4; c++) sw0[c] = m_ack[0][c];
         repeat (10) tick();
         for (int c = 0; c < 4; c++) req[c] = ~m_ack[0][c];
         sw0 = req;
      end
      tick();
      checks++;
      if (bus0.busy_o !== 4'b1111 || bus0.all_stable_o !== 1'b0) begin
         errors++; $display("FAIL concurrent_busy got busy=%b stable=%b expected 1111 0",
                            bus0.busy_o, bus0.all_stable_o);
      end
      repeat (2) tick();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (obs0() !== 17'b0000_0000_0000_0000_1) begin
         errors++; $display("FAIL concurrent_reset got %b expected %b", obs0(), 17'b0000_0000_0000_0000_1);
      end
      model_reset();
      sw0 = 4'b0000; sw1 = 4'b0000;
      bus0.switch_n_i = sw0; bus1.switch_n_i = sw1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (8) begin
         tick();
         checks++;
         if (obs0() !== exp_vec(0)) begin
            errors++; $display("FAIL after_reset got %b expected %b", obs0(), exp_vec(0));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_power_off();
      test_power_on();
      test_abort();
      test_lat1();
      test_random();
      test_concurrent_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
